smc_deadtime: RTL and testbench
===============================

Name: smc_deadtime

Overview:
- Output-conditioning stage directly downstream of the stepper motor controller core (smc).
- Consumes the raw per-channel MNM/MNP drive requests and produces pad-ready drive signals.
- For each channel it guarantees that M and P are never both high, and it inserts a programmable dead time whenever a channel changes drive polarity or is released.
- It also flags illegal overlap requests from the core in a sticky per-channel fault register.

Parameters:
- NCH, 12, number of motor channels (one MNM/MNP bit pair per channel)
- DT_W, 4, width of the dead-time count in QCLK cycles

Ports:
- QCLK  input  1  system clock; all state changes on the rising edge
- QRESET  input  1  asynchronous, active-high reset
- EN  input  1  global output enable; low forces all channels off through dead time
- DEADTIME  input  DT_W  dead-time length in QCLK cycles
- MNM_IN  input  NCH  raw M-side drive request per channel, from smc MNM
- MNP_IN  input  NCH  raw P-side drive request per channel, from smc MNP
- FAULT_CLR  input  1  single-cycle pulse that clears all sticky fault bits
- MNM  output  NCH  conditioned M-side drive to pads
- MNP  output  NCH  conditioned P-side drive to pads
- FAULT  output  NCH  sticky overlap fault per channel
- ACTIVE  output  NCH  per channel, 1 when that channel is in ON_M or ON_P

Behaviour:
- Reset (QRESET high, asynchronous):
  - MNM, MNP, FAULT and ACTIVE = 0.
  - All channel FSMs go to OFF; all counters = 0.
  - Reset is honoured mid-operation, including during DEAD; outputs drop without waiting for a clock.
- Per-channel request decode, evaluated each cycle:
  - req = NONE when EN = 0 or both input bits are 0.
  - req = M when only MNM_IN[i] = 1; req = P when only MNP_IN[i] = 1.
  - When both input bits are 1, req = NONE and FAULT[i] is set (sticky).
- Per-channel FSM states: OFF, ON_M, ON_P, DEAD. All outputs are registered.
  - MNM[i] = 1 only in ON_M; MNP[i] = 1 only in ON_P; both are 0 in OFF and DEAD.
- OFF:
  - req M goes to ON_M; req P goes to ON_P, so the output rises 1 cycle after the request.
  - req NONE stays in OFF.
- ON_M:
  - req M stays in ON_M.
  - Any other req goes to DEAD, loading cnt = DEADTIME-1, or 0 when DEADTIME = 0.
- ON_P: symmetric to ON_M.
- DEAD:
  - While cnt != 0, decrement cnt.
  - When cnt == 0, the next state is determined by the current req: M goes to ON_M, P to ON_P, NONE to OFF.
  - The off gap between opposite drives is therefore max(DEADTIME,1) cycles.
  - Requests made during DEAD are ignored until the count expires; only req at the expiry cycle matters.
- DEADTIME is sampled only on entry to DEAD. Changing it mid-count does not affect a running count.
- EN low while ON_x drops the channel via DEAD, so the dead time is honoured on re-enable.
- FAULT clear rules:
  - FAULT_CLR clears all bits on the next edge.
  - If a new overlap occurs on the same cycle as FAULT_CLR, set wins for that channel.
- Overlap handling: a channel in ON_x that receives an overlap request leaves via DEAD, as for any non-matching req.
- Channels are fully independent; there is no shared timing between channels.
- Invariant, required at every cycle: for each channel i, MNM[i] & MNP[i] == 0.

Decomposition:
- Shared package smc_pkg holds:
  - the channel-state enum {OFF, ON_M, ON_P, DEAD};
  - the request enum {NONE, REQ_M, REQ_P};
  - the NCH and DT_W defaults.
- Sub-module smc_dt_chan contains one channel's FSM, counter and fault bit.
- smc_deadtime instantiates NCH copies of smc_dt_chan via a generate loop. It broadcasts EN, DEADTIME and FAULT_CLR to every channel.

Test Plan:
- Reset and basic drive: with DEADTIME=3 and EN=1, assert MNP_IN[4]=1 from OFF.
  - Required: MNP[4]=1 one cycle later; ACTIVE[4]=1; all other outputs 0.
- Polarity swap with dead time: ch1 in ON_P, DEADTIME=3; switch to MNM_IN[1]=1 and MNP_IN[1]=0.
  - Required: MNP[1]=0 next cycle, both outputs 0 for exactly 3 cycles, then MNM[1]=1.
- Zero dead time: DEADTIME=0, ch0 swaps from ON_M to P.
  - Required: exactly 1 cycle with both outputs 0, then MNP[0]=1.
- Overlap fault: drive MNM_IN[7]=MNP_IN[7]=1 for 1 cycle while ch7 is OFF.
  - Required: MNM[7]=MNP[7]=0 and FAULT[7]=1, held after the inputs clear.
  - Pulse FAULT_CLR: FAULT[7]=0 next cycle.
  - Repeat with the overlap coincident with FAULT_CLR: FAULT[7] must stay 1.
- EN drop and reset mid-DEAD:
  - With DEADTIME=5 and ch2 in ON_M, drop EN. Required: MNM[2]=0 next cycle and ACTIVE[2]=0.
  - Re-enable with P requested after 2 cycles. Required: MNP[2] stays 0 until the 5-cycle dead time expires.
  - Assert QRESET mid-count. Required: all outputs 0 immediately and ch2 in OFF after release.
- Random soak: random MNM_IN/MNP_IN/EN/DEADTIME for 10k cycles.
  - Required: assertion that MNM&MNP==0 always holds.
  - Required: every opposite-polarity transition has a gap of at least max(DEADTIME,1) cycles, using the DEADTIME value sampled at DEAD entry.

Source files
------------

// File: rtl/smc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : smc_pkg
//  Brief    : Shared types and defaults for the smc dead-time output stage.
//             Holds the per-channel state and request encodings and a
//             request decoder used by every channel instance.
//  Revision : 1.0 - initial release
// ============================================================================
package smc_pkg;

  // Default channel count and dead-time counter width
  localparam int NCH_DEFAULT  = 12;
  localparam int DT_W_DEFAULT = 4;

  // Per-channel drive state
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    ON_M = 2'd1,
    ON_P = 2'd2,
    DEAD = 2'd3
  } chan_state_e;

  // Decoded drive request for one channel
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    REQ_M = 2'd1,
    REQ_P = 2'd2
  } chan_req_e;

  // An overlapping request (both bits set) decodes to NONE so the channel
  // is released; the overlap itself is flagged separately as a fault.
  function automatic chan_req_e decode_req(input logic en,
                                           input logic m_req,
                                           input logic p_req);
    chan_req_e req;
    req = NONE;
    if (en) begin
      if (m_req && !p_req) begin
        req = REQ_M;
      end else if (p_req && !m_req) begin
        req = REQ_P;
      end
    end
    return req;
  endfunction

endpackage : smc_pkg
`default_nettype wire

// File: rtl/smc_dt_chan.sv
`default_nettype none
// ============================================================================
//  Module   : smc_dt_chan
//  Brief    : One motor channel of the dead-time stage: drive FSM, dead-time
//             down-counter and sticky overlap fault bit. Drive outputs are
//             registered and can never be high together.
//  Revision : 1.0 - initial release
// ============================================================================
module smc_dt_chan
  import smc_pkg::*;
#(
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [DT_W-1:0] deadtime_i,
  input  logic            m_req_i,
  input  logic            p_req_i,
  input  logic            fault_clr_i,
  output logic            mnm_o,
  output logic            mnp_o,
  output logic            fault_o,
  output logic            active_o
);

  chan_state_e     state_q;
  logic [DT_W-1:0] cnt_q;
  logic            mnm_q;
  logic            mnp_q;
  logic            active_q;
  logic            fault_q;
  logic            fault_d;

  chan_req_e       req_w;
  logic            overlap_w;
  logic [DT_W-1:0] dt_load_w;

  // Request decode and dead-time load value; a zero dead time still costs
  // one DEAD cycle, so the load saturates at zero.
  always_comb begin
    overlap_w = m_req_i & p_req_i;
    req_w     = decode_req(en_i, m_req_i, p_req_i);
    dt_load_w = (deadtime_i == '0) ? '0 : (deadtime_i - DT_W'(1));
  end

  // Drive FSM; outputs are registered and reflect the state being entered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      mnm_q    <= 1'b0;
      mnp_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      mnm_q    <= 1'b0;
      mnp_q    <= 1'b0;
      active_q <= 1'b0;
      case (state_q)
        OFF: begin
          if (req_w == REQ_M) begin
            state_q  <= ON_M;
            mnm_q    <= 1'b1;
            active_q <= 1'b1;
          end else if (req_w == REQ_P) begin
            state_q  <= ON_P;
            mnp_q    <= 1'b1;
            active_q <= 1'b1;
          end
        end
        ON_M: begin
          if (req_w == REQ_M) begin
            mnm_q    <= 1'b1;
            active_q <= 1'b1;
          end else begin
            state_q <= DEAD;
            cnt_q   <= dt_load_w;
          end
        end
        ON_P: begin
          if (req_w == REQ_P) begin
            mnp_q    <= 1'b1;
            active_q <= 1'b1;
          end else begin
            state_q <= DEAD;
            cnt_q   <= dt_load_w;
          end
        end
        DEAD: begin
          // Requests are ignored until the count has run out
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - DT_W'(1);
          end else if (req_w == REQ_M) begin
            state_q  <= ON_M;
            mnm_q    <= 1'b1;
            active_q <= 1'b1;
          end else if (req_w == REQ_P) begin
            state_q  <= ON_P;
            mnp_q    <= 1'b1;
            active_q <= 1'b1;
          end else begin
            state_q <= OFF;
          end
        end
        default: begin
          state_q <= OFF;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Sticky fault next value: a new overlap beats a simultaneous clear
  always_comb begin
    fault_d = fault_q;
    if (fault_clr_i) begin
      fault_d = 1'b0;
    end
    if (overlap_w) begin
      fault_d = 1'b1;
    end
  end

  // Sticky fault register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign mnm_o    = mnm_q;
  assign mnp_o    = mnp_q;
  assign active_o = active_q;
  assign fault_o  = fault_q;

endmodule : smc_dt_chan
`default_nettype wire

// File: rtl/smc_deadtime.sv
`default_nettype none
// ============================================================================
//  Module   : smc_deadtime
//  Brief    : Output-conditioning stage after the stepper motor controller
//             core. Replicates one independent dead-time channel per motor
//             output pair and broadcasts the global controls to all of them.
//  Revision : 1.0 - initial release
// ============================================================================
module smc_deadtime
  import smc_pkg::*;
#(
  parameter int NCH  = NCH_DEFAULT,
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            QCLK,
  input  logic            QRESET,
  input  logic            EN,
  input  logic [DT_W-1:0] DEADTIME,
  input  logic [NCH-1:0]  MNM_IN,
  input  logic [NCH-1:0]  MNP_IN,
  input  logic            FAULT_CLR,
  output logic [NCH-1:0]  MNM,
  output logic [NCH-1:0]  MNP,
  output logic [NCH-1:0]  FAULT,
  output logic [NCH-1:0]  ACTIVE
);

  // One fully independent channel per MNM/MNP bit pair
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    smc_dt_chan #(
      .DT_W (DT_W)
    ) u_chan (
      .clk_i       (QCLK),
      .rst_i       (QRESET),
      .en_i        (EN),
      .deadtime_i  (DEADTIME),
      .m_req_i     (MNM_IN[gi]),
      .p_req_i     (MNP_IN[gi]),
      .fault_clr_i (FAULT_CLR),
      .mnm_o       (MNM[gi]),
      .mnp_o       (MNP[gi]),
      .fault_o     (FAULT[gi]),
      .active_o    (ACTIVE[gi])
    );
  end

endmodule : smc_deadtime
`default_nettype wire

// File: tb/tb_smc_deadtime.sv
`default_nettype none
// ============================================================================
//  Module   : tb_smc_deadtime
//  Brief    : Directed and random-soak bench for smc_deadtime.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_smc_deadtime;

  localparam int NCH  = 12;
  localparam int DT_W = 4;

  logic            QCLK;
  logic            QRESET;
  logic            EN;
  logic [DT_W-1:0] DEADTIME;
  logic [NCH-1:0]  MNM_IN;
  logic [NCH-1:0]  MNP_IN;
  logic            FAULT_CLR;
  logic [NCH-1:0]  MNM;
  logic [NCH-1:0]  MNP;
  logic [NCH-1:0]  FAULT;
  logic [NCH-1:0]  ACTIVE;

  int n_vec;
  int n_err;
  int ov_errs;

  smc_deadtime #(
    .NCH  (NCH),
    .DT_W (DT_W)
  ) dut (
    .QCLK      (QCLK),
    .QRESET    (QRESET),
    .EN        (EN),
    .DEADTIME  (DEADTIME),
    .MNM_IN    (MNM_IN),
    .MNP_IN    (MNP_IN),
    .FAULT_CLR (FAULT_CLR),
    .MNM       (MNM),
    .MNP       (MNP),
    .FAULT     (FAULT),
    .ACTIVE    (ACTIVE)
  );

  initial QCLK = 1'b0;
  always #5 QCLK = ~QCLK;

  // M and P must never be driven together on any channel
  always @(negedge QCLK) begin
    if (!QRESET) begin
      if ((MNM & MNP) != '0) ov_errs++;
      assert ((MNM & MNP) == '0) else $error("overlap on pads %h", MNM & MNP);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge QCLK);
    #1;
  endtask

  // Soak tracking state
  logic [1:0] prev_out [NCH];
  int         zcnt     [NCH];
  int         req_gap  [NCH];
  int         gap_errs;
  int         drives;
  int         hold;
  logic [DT_W-1:0] prev_dt;

  initial begin
    n_vec = 0; n_err = 0; ov_errs = 0; gap_errs = 0; drives = 0;
    QRESET = 1'b1; EN = 1'b0; DEADTIME = '0; MNM_IN = '0; MNP_IN = '0; FAULT_CLR = 1'b0;
    #1;
    chk("rst_mnm", MNM, 0);
    chk("rst_mnp", MNP, 0);
    chk("rst_fault", FAULT, 0);
    chk("rst_active", ACTIVE, 0);
    #20;
    QRESET = 1'b0;
    tick();

    // Basic drive from OFF on ch4
    DEADTIME = 4'd3; EN = 1'b1; MNP_IN = 12'h010;
    chk("basic_pre", MNP, 0);
    tick();
    chk("basic_mnp", MNP, 12'h010);
    chk("basic_active", ACTIVE, 12'h010);
    chk("basic_mnm", MNM, 0);
    chk("basic_fault", FAULT, 0);
    MNP_IN = '0;
    repeat (6) tick();

    // Polarity swap on ch1 with DEADTIME=3
    MNP_IN = 12'h002;
    tick();
    chk("swap_on_p", MNP, 12'h002);
    MNP_IN = '0; MNM_IN = 12'h002;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("swap_gap_mnp", MNP, 0);
      chk("swap_gap_mnm", MNM, 0);
    end
    tick();
    chk("swap_on_m", MNM, 12'h002);
    MNM_IN = '0;
    repeat (6) tick();

    // Zero dead time on ch0: M -> P with a single off cycle
    DEADTIME = 4'd0; MNM_IN = 12'h001;
    tick();
    chk("dt0_on_m", MNM, 12'h001);
    MNM_IN = '0; MNP_IN = 12'h001;
    tick();
    chk("dt0_gap", MNM | MNP, 0);
    tick();
    chk("dt0_on_p", MNP, 12'h001);
    MNP_IN = '0;
    repeat (4) tick();

    // Overlap fault on ch7
    MNM_IN = 12'h080; MNP_IN = 12'h080;
    tick();
    chk("ovl_outs", MNM | MNP, 0);
    chk("ovl_fault", FAULT, 12'h080);
    MNM_IN = '0; MNP_IN = '0;
    tick();
    chk("ovl_sticky", FAULT, 12'h080);
    FAULT_CLR = 1'b1;
    tick();
    FAULT_CLR = 1'b0;
    chk("ovl_clear", FAULT, 0);
    MNM_IN = 12'h080; MNP_IN = 12'h080;
    tick();
    chk("ovl_reset", FAULT, 12'h080);
    FAULT_CLR = 1'b1;
    tick();
    FAULT_CLR = 1'b0; MNM_IN = '0; MNP_IN = '0;
    chk("ovl_set_wins", FAULT, 12'h080);
    FAULT_CLR = 1'b1;
    tick();
    FAULT_CLR = 1'b0;
    chk("ovl_clear2", FAULT, 0);
    repeat (2) tick();

    // EN drop with DEADTIME=5 while ch2 (and ch5) drive M
    DEADTIME = 4'd5; MNM_IN = 12'h024;
    tick();
    chk("en_on_m", MNM, 12'h024);
    EN = 1'b0;
    tick();
    chk("en_drop_mnm", MNM, 0);
    chk("en_drop_active", ACTIVE, 0);
    tick();
    EN = 1'b1; MNM_IN = 12'h020; MNP_IN = 12'h004;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("en_dead_mnp", MNP, 0);
    end
    tick();
    chk("en_reen_mnp", MNP, 12'h004);
    chk("en_reen_mnm", MNM, 12'h020);
    MNP_IN = '0;
    repeat (2) tick();
    chk("rst_pre_mnm", MNM, 12'h020);
    QRESET = 1'b1;
    #1;
    chk("rst_mid_mnm", MNM, 0);
    chk("rst_mid_mnp", MNP, 0);
    chk("rst_mid_active", ACTIVE, 0);
    MNM_IN = '0;
    #3;
    QRESET = 1'b0;
    tick();
    chk("rst_rel_active", ACTIVE, 0);
    MNP_IN = 12'h004;
    tick();
    chk("rst_rel_off", MNP, 12'h004);
    MNP_IN = '0;

    // Let every channel settle to OFF before the soak
    EN = 1'b0;
    repeat (20) tick();
    for (int i = 0; i < NCH; i++) begin
      prev_out[i] = 2'd0; zcnt[i] = 0; req_gap[i] = 0;
    end

    // Random soak
    hold = 0;
    for (int c = 0; c < 10000; c++) begin
      if (hold == 0) begin
        MNM_IN = NCH'($urandom);
        MNP_IN = NCH'($urandom) & ~NCH'($urandom);
        EN     = ($urandom_range(0, 15) != 0);
        hold   = $urandom_range(1, 12);
      end
      hold--;
      DEADTIME = DT_W'($urandom);
      prev_dt  = DEADTIME;
      tick();
      for (int i = 0; i < NCH; i++) begin
        logic [1:0] cur;
        cur = {MNP[i], MNM[i]};
        if (prev_out[i] != 2'd0 && cur != 2'd0 && cur != prev_out[i]) begin
          gap_errs++;
        end else if (prev_out[i] != 2'd0 && cur == 2'd0) begin
          zcnt[i]    = 1;
          req_gap[i] = (prev_dt == '0) ? 1 : int'(prev_dt);
        end else if (prev_out[i] == 2'd0 && cur == 2'd0) begin
          zcnt[i]++;
        end else if (prev_out[i] == 2'd0 && cur != 2'd0) begin
          drives++;
          if (req_gap[i] > 0 && zcnt[i] < req_gap[i]) gap_errs++;
          req_gap[i] = 0;
        end
        prev_out[i] = cur;
      end
    end
    chk("soak_overlap", ov_errs, 0);
    chk("soak_gap", gap_errs, 0);
    chk("soak_activity", (drives > 100) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_smc_deadtime
`default_nettype wire
